stopwatch_bcd_core: RTL and testbench
=====================================

// Module: stopwatch_bcd_core
// PURPOSE
//  Upstream timing stage of the 4-digit seven-segment display path: a stopwatch that counts
//  centiseconds in packed BCD (SS.cc, 00.00..99.99) and generates the display scan strobe.
//  Its cntr/dispen outputs drive the display controller directly. Raw push-buttons start,
//  pause, resume and clear it.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency, Hz
//  TICK_HZ     100         count rate, Hz (1 count = 0.01 s)
//  SCAN_HZ     1000        dispen strobe rate, Hz (one digit step per strobe)
//  DEB_CYCLES  500_000     cycles a synchronised button must be stable to register (10 ms)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous reset, active-low (0 = reset)
//  btn_start  in   1   raw start/pause button, active-high, asynchronous to clk
//  btn_clear  in   1   raw clear button, active-high, asynchronous to clk
//  dispen     out  1   scan strobe, one-cycle pulse every CLK_HZ/SCAN_HZ cycles
//  cntr       out  16  BCD digits {sec10,sec1,cs10,cs1}; [3:0] = hundredths
//  running    out  1   1 while state == RUN
//  overflow   out  1   1 while state == OVF
// BEHAVIOUR
//  Reset (rst=0): state IDLE, cntr=16'h0000, dispen=0, running=0, overflow=0, all dividers and
//   debounce counters 0. All outputs are registered.
//  Buttons: 2-FF synchroniser -> debounce (output changes only after DEB_CYCLES consecutive
//   equal samples) -> rising-edge detect -> 1-cycle press pulse. Latency from a stable raw
//   level to the pulse is 2+DEB_CYCLES cycles (+-1). Holding a button yields exactly one pulse.
//  Scan divider: SCAN_DIV=CLK_HZ/SCAN_HZ. It free-runs 0..SCAN_DIV-1 in every state and asserts
//   dispen for the single cycle at SCAN_DIV-1. It is never gated by the FSM.
//  Tick divider: TICK_DIV=CLK_HZ/TICK_HZ, range 0..TICK_DIV-1.
//   - Advances only in RUN. Holds its value in PAUSE, so the partial centisecond is kept.
//   - Cleared in IDLE and on clear.
//   - At TICK_DIV-1 in RUN it wraps to 0, and cntr increments on the same edge.
//  Divider widths are $clog2 of the divisor. Divisors are integer; a remainder is truncated.
//  BCD increment: a digit at 9 wraps to 0 and carries into the next digit. Digits never hold
//   A-F. A digit above 9 is unreachable by design and is not corrected.
//  FSM (start = start pulse, clear = clear pulse):
//   IDLE : start -> RUN
//   RUN  : start -> PAUSE; tick with cntr==16'h9999 -> OVF (cntr holds 9999, overflow=1)
//   PAUSE: start -> RUN (counting resumes from the held divider value)
//   OVF  : start ignored
//   any  : clear -> IDLE, cntr=0, tick divider=0, overflow=0
//  Simultaneous events:
//   - clear and start pulses in the same cycle: clear wins and start is discarded.
//   - start pulse in the same cycle as a RUN tick: the tick increment is applied and the
//     state becomes PAUSE.
//  Reset mid-operation aborts immediately: no output glitch beyond the reset values, and
//   counting restarts only on a new start pulse.
//  running/overflow are decoded from the next-state register, so they are valid in the same
//   cycle as the state.
// STRUCTURE
//  Shared include stopwatch_defs.vh holds:
//   - FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_OVF=2'd3
//   - BCD_MAX=4'd9
//   - CNTR_MAX=16'h9999
//  One sub-module, btn_debounce (synchroniser + debounce + edge pulse; parameter DEB_CYCLES),
//  instantiated twice. The dividers, BCD chain and FSM stay in this module.
// TESTING (bench overrides: CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10, SCAN_HZ=250 -> SCAN_DIV=4,
//  DEB_CYCLES=3)
//  1 Reset/scan: hold rst=0 5 cycles, release -> cntr=0000, running=0, overflow=0; dispen=1 on
//    exactly 1 of every 4 cycles, first pulse 4 cycles after release.
//  2 Start/count: press start 10 cycles -> running=1 within 2+3+2 cycles; 120 cycles later
//    cntr=0012 (+-1). Confirm: 0009->0010 and 0099->0100 carries; no nibble ever > 9.
//  3 Pause/resume: pause when the divider=6, wait 50 cycles -> cntr frozen, running=0;
//    resume -> next increment after exactly 4 cycles.
//  4 Overflow: force cntr=9998 in RUN -> after 2 ticks cntr=9999, overflow=1, running=0;
//    a start press changes nothing; clear -> cntr=0000, overflow=0, IDLE.
//  5 Bounce/priority: toggle btn_start every cycle for 10 cycles then hold -> one start pulse
//    only; clear and start pulses in the same cycle during RUN -> IDLE, cntr=0000.
//  6 Async reset: assert rst mid-RUN between clock edges -> outputs reach reset values before
//    the next edge; after release, cntr stays 0000 until a new start press.

Source files
------------

// File: rtl/stopwatch_bcd_core_pkg.sv
// Shared definitions for the stopwatch core: FSM state encoding, BCD limits
// and the packed-BCD increment helper.
package stopwatch_bcd_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVF   = 2'd3
    } sw_state_t;

    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [15:0] CNTR_MAX = 16'h9999;

    // Increment a 4-digit packed BCD value; a digit at 9 wraps to 0 and
    // carries into the next digit. Digits above 9 are not corrected.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (result[i*4 +: 4] == BCD_MAX) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_core_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce filter that only
// changes its level after DEB_CYCLES consecutive differing samples, and a
// one-cycle pulse on every debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive samples that disagree with the debounced level and
    // flip the level (emitting a pulse on a rise) once enough have been seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (sync2 != level) begin
            if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                pulse <= sync2;
            end else begin
                cnt   <= cnt + CNT_W'(1);
                pulse <= 1'b0;
            end
        end else begin
            cnt   <= '0;
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_bcd_core.sv
// Stopwatch counting centiseconds in packed BCD (SS.cc) with a free-running
// display scan strobe and start/pause/resume/clear button control.
module stopwatch_bcd_core
    import stopwatch_bcd_core_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int SCAN_HZ    = 1000,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_clear,
    output logic        dispen,
    output logic [15:0] cntr,
    output logic        running,
    output logic        overflow
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    sw_state_t         state;
    sw_state_t         state_next;
    logic [SCAN_W-1:0] scan_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic              start_p;
    logic              clear_p;
    logic              tick;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start),
        .pulse (start_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .pulse (clear_p)
    );

    assign tick = (state == ST_RUN) && (tick_cnt == TICK_W'(TICK_DIV - 1));

    // Free-running scan divider; the strobe is a registered decode of the last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            dispen   <= 1'b0;
        end else begin
            dispen   <= (scan_cnt == SCAN_W'(SCAN_DIV - 1));
            scan_cnt <= (scan_cnt == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_cnt + SCAN_W'(1);
        end
    end

    // State register; status flags decode the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            running  <= (state_next == ST_RUN);
            overflow <= (state_next == ST_OVF);
        end
    end

    // Next-state logic: clear beats everything, overflow beats a coincident start.
    always_comb begin
        state_next = state;
        if (clear_p) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_p) state_next = ST_RUN;
                ST_RUN: begin
                    if (tick && (cntr == CNTR_MAX)) state_next = ST_OVF;
                    else if (start_p)               state_next = ST_PAUSE;
                end
                ST_PAUSE: if (start_p) state_next = ST_RUN;
                ST_OVF:   state_next = ST_OVF;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Tick divider advances only while running and keeps its phase across a pause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (clear_p || (state == ST_IDLE)) begin
            tick_cnt <= '0;
        end else if (state == ST_RUN) begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    // BCD count register; it holds at 9999 when the overflow tick arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntr <= 16'h0000;
        end else if (clear_p) begin
            cntr <= 16'h0000;
        end else if (tick && (cntr != CNTR_MAX)) begin
            cntr <= bcd_inc(cntr);
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Self-checking bench for stopwatch_bcd_core: directed scenarios plus a
// randomized button phase, all compared every cycle against a behavioural model.
module tb_stopwatch_bcd_core;

    localparam int CLK_HZ     = 1000;
    localparam int TICK_HZ    = 100;
    localparam int SCAN_HZ    = 250;
    localparam int DEB_CYCLES = 3;
    localparam int TICK_DIV   = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
    localparam int HIST       = 16384;
    localparam int MAX_COUNT  = 9999;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVF   = 3;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic        dispen;
    logic        running;
    logic        overflow;
    logic [15:0] cntr;

    int assert_count = 0;
    int fail_count   = 0;

    // Behavioural model: count in plain centiseconds, phase within the tick period,
    // cycles since reset, debounced levels and pending press pulses.
    int  m_mode;
    int  m_count;
    int  m_phase;
    int  m_cyc;
    bit  m_lvl   [2];
    bit  m_pulse [2];
    bit  raw_hist [2][HIST];

    logic [15:0] prev_cntr = 16'h0000;
    bit          seen_c10  = 1'b0;
    bit          seen_c100 = 1'b0;

    always #5 clk = ~clk;

    stopwatch_bcd_core #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .SCAN_HZ    (SCAN_HZ),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .dispen    (dispen),
        .cntr      (cntr),
        .running   (running),
        .overflow  (overflow)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Synchronised button value seen at edge j: the raw level sampled two edges earlier.
    function automatic bit sync_val(input int b, input int j);
        return (j > 2) ? raw_hist[b][j-3] : 1'b0;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_count = 0;
        m_phase = 0;
        m_cyc   = 0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b]   = 1'b0;
            m_pulse[b] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit s;
        bit c;
        bit flip;
        int j;
        if (!rst) begin
            model_reset();
            return;
        end
        m_cyc++;
        j = m_cyc;
        s = m_pulse[0];
        c = m_pulse[1];
        if (j <= HIST) begin
            raw_hist[0][j-1] = btn_start;
            raw_hist[1][j-1] = btn_clear;
        end
        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int i = 0; i < DEB_CYCLES; i++) begin
                if ((j - i) < 1 || (j - i) > HIST + 2 || sync_val(b, j - i) == m_lvl[b]) flip = 1'b0;
            end
            if (flip) m_lvl[b] = ~m_lvl[b];
            m_pulse[b] = flip && m_lvl[b];
        end
        if (c) begin
            m_mode  = M_IDLE;
            m_count = 0;
            m_phase = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_phase = 0;
                    if (s) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (m_phase == TICK_DIV - 1) begin
                        m_phase = 0;
                        if (m_count == MAX_COUNT) begin
                            m_mode = M_OVF;
                        end else begin
                            m_count++;
                            if (s) m_mode = M_PAUSE;
                        end
                    end else begin
                        m_phase++;
                        if (s) m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (s) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        logic nib_bad;
        nib_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cntr[i*4 +: 4] > 4'd9) nib_bad = 1'b1;
        end
        check_val("cntr",     {16'h0, cntr},     {16'h0, to_bcd(m_count)});
        check_val("running",  {31'h0, running},  {31'h0, (m_mode == M_RUN)});
        check_val("overflow", {31'h0, overflow}, {31'h0, (m_mode == M_OVF)});
        check_val("dispen",   {31'h0, dispen},   {31'h0, (m_cyc > 0 && (m_cyc % SCAN_DIV) == 0)});
        check_val("nibble_le_9", {31'h0, nib_bad}, 32'h0);
    endtask

    task automatic clock_step();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
        if (prev_cntr == 16'h0009 && cntr == 16'h0010) seen_c10 = 1'b1;
        if (prev_cntr == 16'h0099 && cntr == 16'h0100) seen_c100 = 1'b1;
        prev_cntr = cntr;
    endtask

    task automatic apply_stimulus(input bit s, input bit c);
        btn_start = s;
        btn_clear = c;
    endtask

    // Global time bound so a stuck run still terminates.
    initial begin
        #(8000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          first;
        int          pulses;
        int          lat;
        int          k;
        int          resumed;
        int          lat2;
        int          rises;
        int          r;
        int          len;
        bit          found;
        bit          prev_run;
        logic [15:0] frozen;
        logic [15:0] held;

        model_reset();
        apply_stimulus(0, 0);
        #1 rst = 1'b0;

        // Reset held for five cycles, then released between edges.
        repeat (5) clock_step();
        #4 rst = 1'b1;

        // Scan strobe: first pulse on the fourth edge, one in every four.
        first  = 0;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            clock_step();
            if (dispen) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check_val("scan_first_pulse", 32'(first), 32'd4);
        check_val("scan_pulse_count", 32'(pulses), 32'd3);

        // Start and count.
        $display("[TB] start and count");
        apply_stimulus(1, 0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            clock_step();
            if (lat == 0 && running) lat = i;
        end
        apply_stimulus(0, 0);
        check_val("start_latency_le_7", {31'h0, (lat > 0 && lat <= 7)}, 32'd1);
        for (int i = 0; i < lat + 110; i++) clock_step();
        check_val("count_after_120", {31'h0, (cntr >= 16'h0011 && cntr <= 16'h0013)}, 32'd1);
        k = 0;
        while (!seen_c100 && k < 1200) begin
            clock_step();
            k++;
        end
        check_val("carry_0009_0010", {31'h0, seen_c10}, 32'd1);
        check_val("carry_0099_0100", {31'h0, seen_c100}, 32'd1);

        // Pause with the divider holding 6, then resume.
        $display("[TB] pause and resume");
        k = 0;
        while (!(m_mode == M_RUN && m_phase == 0) && k < 20) begin
            clock_step();
            k++;
        end
        apply_stimulus(1, 0);
        repeat (8) clock_step();
        apply_stimulus(0, 0);
        repeat (4) clock_step();
        frozen = to_bcd(m_count);
        repeat (50) clock_step();
        check_val("pause_frozen", {16'h0, cntr}, {16'h0, frozen});
        check_val("pause_running", {31'h0, running}, 32'd0);
        apply_stimulus(1, 0);
        resumed = 0;
        lat2    = 0;
        held    = 16'h0000;
        for (int i = 1; i <= 30; i++) begin
            if (i == 9) apply_stimulus(0, 0);
            clock_step();
            if (resumed == 0 && running) begin
                resumed = i;
                held    = cntr;
            end else if (resumed != 0 && cntr != held) begin
                lat2 = i - resumed;
                break;
            end
        end
        apply_stimulus(0, 0);
        check_val("resume_latency", 32'(lat2), 32'd4);

        // Overflow from 9998.
        $display("[TB] overflow");
        force dut.cntr = 16'h9998;
        #1 release dut.cntr;
        m_count = MAX_COUNT - 1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            clock_step();
            if (overflow) begin
                found = 1'b1;
                break;
            end
        end
        check_val("overflow_reached", {31'h0, found}, 32'd1);
        check_val("overflow_cntr", {16'h0, cntr}, 32'h9999);
        check_val("overflow_running", {31'h0, running}, 32'd0);
        apply_stimulus(1, 0);
        repeat (8) clock_step();
        apply_stimulus(0, 0);
        repeat (10) clock_step();
        check_val("ovf_start_ignored", {31'h0, overflow}, 32'd1);
        check_val("ovf_cntr_held", {16'h0, cntr}, 32'h9999);
        apply_stimulus(0, 1);
        repeat (8) clock_step();
        apply_stimulus(0, 0);
        repeat (8) clock_step();
        check_val("clear_overflow", {31'h0, overflow}, 32'd0);
        check_val("clear_cntr", {16'h0, cntr}, 32'h0);
        check_val("clear_running", {31'h0, running}, 32'd0);

        // Bouncing start then a hold yields exactly one press.
        $display("[TB] bounce and priority");
        r        = int'($urandom_range(0, 1));
        rises    = 0;
        prev_run = running;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(bit'((i + r) % 2), 0);
            clock_step();
            if (running && !prev_run) rises++;
            prev_run = running;
        end
        apply_stimulus(1, 0);
        for (int i = 0; i < 15; i++) begin
            clock_step();
            if (running && !prev_run) rises++;
            prev_run = running;
        end
        check_val("bounce_one_press", 32'(rises), 32'd1);
        check_val("bounce_running", {31'h0, running}, 32'd1);
        apply_stimulus(0, 0);
        repeat (10) clock_step();
        apply_stimulus(1, 1);
        repeat (8) clock_step();
        apply_stimulus(0, 0);
        repeat (10) clock_step();
        check_val("clear_wins_running", {31'h0, running}, 32'd0);
        check_val("clear_wins_cntr", {16'h0, cntr}, 32'h0);

        // Randomized button activity against the model.
        $display("[TB] random buttons");
        for (int seg = 0; seg < 40; seg++) begin
            len = int'($urandom_range(1, 12));
            apply_stimulus(bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            repeat (len) clock_step();
        end
        apply_stimulus(0, 0);
        repeat (10) clock_step();

        // Asynchronous reset in the middle of a run.
        $display("[TB] async reset");
        apply_stimulus(0, 1);
        repeat (8) clock_step();
        apply_stimulus(0, 0);
        repeat (8) clock_step();
        apply_stimulus(1, 0);
        repeat (8) clock_step();
        apply_stimulus(0, 0);
        repeat (20) clock_step();
        check_val("pre_reset_running", {31'h0, running}, 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_val("async_cntr", {16'h0, cntr}, 32'h0);
        check_val("async_running", {31'h0, running}, 32'd0);
        check_val("async_overflow", {31'h0, overflow}, 32'd0);
        check_val("async_dispen", {31'h0, dispen}, 32'd0);
        repeat (3) clock_step();
        #4 rst = 1'b1;
        repeat (30) clock_step();
        check_val("post_reset_cntr", {16'h0, cntr}, 32'h0);
        check_val("post_reset_running", {31'h0, running}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
